// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
// Bundles the CPU port, the DMA port and the external SRAM pins of the
// arbiter so that they can be passed as a single port.
//   slave  : the arbiter side (receives requests, drives the SRAM pins)
//   master : the environment side (CPU, DMA engine and SRAM device)
// Signal groups:
//   cpu_*  : CPU request/address/write strobe/data, cpu_rdata, cpu_rdy
//   dma_*  : DMA request/address/write strobe/data, dma_ack, dma_rdata
//   sram_* : registered sram_addr/sram_dout/sram_we, async sram_din
interface sram_arbiter_if;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;

  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_we;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;

  logic [15:0] sram_addr;
  logic [7:0]  sram_dout;
  logic [7:0]  sram_din;
  logic        sram_we;

  modport slave (
    input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
    output cpu_rdata, cpu_rdy,
    input  dma_req, dma_addr, dma_we, dma_wdata,
    output dma_ack, dma_rdata,
    output sram_addr, sram_dout, sram_we,
    input  sram_din
  );

  modport master (
    output cpu_req, cpu_addr, cpu_we, cpu_wdata,
    input  cpu_rdata, cpu_rdy,
    output dma_req, dma_addr, dma_we, dma_wdata,
    input  dma_ack, dma_rdata,
    input  sram_addr, sram_dout, sram_we,
    output sram_din
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one asynchronous-read SRAM between a CPU and a DMA engine. A grant
// decided in cycle N registers the winner's address/data/write strobe onto
// the SRAM pins so the access occupies cycle N+1. CPU reads see sram_din
// directly; DMA reads are captured at the end of N+1 and acknowledged with
// a one-cycle dma_ack pulse in N+2.
// Optional feature macro: SRAM_ARB_STARVE_EN
//   defined   : an 8-bit starve counter forces a DMA slot after STARVE_MAX
//               consecutive DMA wait cycles, stalling the CPU (cpu_rdy=0)
//               for that one cycle.
//   undefined : CPU has absolute priority, cpu_rdy is tied high.
// Ports:
//   clk   : system clock, all logic on posedge
//   reset : synchronous active-high reset
//   bus   : sram_arbiter_if.slave (CPU, DMA and SRAM signal groups)
module sram_arbiter #(
  parameter int unsigned STARVE_MAX = 8
) (
  input logic           clk,
  input logic           reset,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    DMA  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] sram_addr_reg, sram_addr_next;
  logic [7:0]  sram_dout_reg, sram_dout_next;
  logic        sram_we_reg, sram_we_next;
  logic        dma_ack_reg;
  logic [7:0]  dma_rdata_reg;
  logic        forced;
  logic        grant_cpu;
  logic        grant_dma;
  logic        dma_busy;

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("STARVE_MAX must be within 1..255");
  end

  // A DMA access in flight blocks a second grant for the same request.
  assign dma_busy  = (state_reg == DMA);
  assign grant_cpu = bus.cpu_req && !forced;
  assign grant_dma = !grant_cpu && bus.dma_req && !dma_busy;

`ifdef SRAM_ARB_STARVE_EN
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] starve_reg, starve_next;

  // Forcing only matters when the CPU would otherwise win the slot.
  assign forced = !reset && bus.cpu_req && bus.dma_req && !dma_busy &&
                  (starve_reg >= STARVE_LIM);

  always_comb begin
    starve_next = starve_reg;
    if (!bus.dma_req || grant_dma) begin
      starve_next = '0;
    end else if (starve_reg < STARVE_LIM) begin
      starve_next = starve_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_reg <= '0;
    end else begin
      starve_reg <= starve_next;
    end
  end
`else
  assign forced = 1'b0;
`endif

  always_comb begin
    state_next     = IDLE;
    sram_addr_next = sram_addr_reg;
    sram_dout_next = sram_dout_reg;
    sram_we_next   = 1'b0;
    if (grant_cpu) begin
      state_next     = CPU;
      sram_addr_next = bus.cpu_addr;
      sram_dout_next = bus.cpu_wdata;
      sram_we_next   = bus.cpu_we;
    end else if (grant_dma) begin
      state_next     = DMA;
      sram_addr_next = bus.dma_addr;
      sram_dout_next = bus.dma_wdata;
      sram_we_next   = bus.dma_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      sram_addr_reg <= '0;
      sram_dout_reg <= '0;
      sram_we_reg   <= 1'b0;
      dma_ack_reg   <= 1'b0;
      dma_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sram_addr_reg <= sram_addr_next;
      sram_dout_reg <= sram_dout_next;
      sram_we_reg   <= sram_we_next;
      // Ack follows the DMA access cycle; read data is kept until the
      // next DMA read so writes leave the last read value untouched.
      dma_ack_reg   <= dma_busy;
      if (dma_busy && !sram_we_reg) begin
        dma_rdata_reg <= bus.sram_din;
      end
    end
  end

  assign bus.sram_addr = sram_addr_reg;
  assign bus.sram_dout = sram_dout_reg;
  assign bus.sram_we   = sram_we_reg;
  assign bus.dma_ack   = dma_ack_reg;
  assign bus.dma_rdata = dma_rdata_reg;
  assign bus.cpu_rdata = bus.sram_din;
  assign bus.cpu_rdy   = !forced;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
// Self-checking bench for sram_arbiter: directed scenarios plus a random
// CPU/DMA mix, all checked against a transaction-level reference model of
// the arbitration rules and an array model of the SRAM contents.
module tb_sram_arbiter;
  localparam int STARVE_MAX = 8;
`ifdef SRAM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  sram_arbiter_if bus();
  sram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (.clk(clk), .reset(reset), .bus(bus));

  // SRAM device: asynchronous read, write on the clock edge.
  logic [7:0]  mem [0:65535];
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;
  assign bus.sram_din = mem[bus.sram_addr];
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_dout;
  end

  int n_checks;
  int n_fail;
  int cyc;

  logic [15:0] paddr [8] = '{16'h0200, 16'h0201, 16'h0305, 16'h3010,
                             16'h3011, 16'h3ABC, 16'h0FFF, 16'h3FFF};
  logic [7:0]  pdata [8];
  logic [7:0]  mm [int];

  // Model: e_* = expected this cycle, n_* = expected after the next edge.
  logic [15:0] e_addr, n_addr;
  logic [7:0]  e_dout, n_dout, e_rdata, n_rdata, e_cpu_rdata;
  logic        e_we, n_we, e_ack, n_ack, e_busy, n_busy, e_dma_rd, n_dma_rd;
  logic        e_cpu_rd, n_cpu_rd, e_rdy;
  int          starve, n_starve;

  task automatic step(input bit rst, input bit creq, input logic [15:0] caddr,
                      input bit cwe, input logic [7:0] cwd, input bit dreq,
                      input logic [15:0] daddr, input bit dwe, input logic [7:0] dwd);
    bit forced, gc, gd;
    logic [7:0] rd_val;
    @(negedge clk);
    e_addr = n_addr; e_dout = n_dout; e_we = n_we; e_ack = n_ack;
    e_rdata = n_rdata; e_busy = n_busy; e_dma_rd = n_dma_rd;
    e_cpu_rd = n_cpu_rd; starve = n_starve;
    reset = rst;
    bus.cpu_req = creq; bus.cpu_addr = caddr; bus.cpu_we = cwe; bus.cpu_wdata = cwd;
    bus.dma_req = dreq; bus.dma_addr = daddr; bus.dma_we = dwe; bus.dma_wdata = dwd;
    #1;
    forced = STARVE_EN && !rst && creq && dreq && !e_busy && (starve >= STARVE_MAX);
    e_rdy = !forced;
    gc = creq && !forced;
    gd = !gc && dreq && !e_busy;
    e_cpu_rdata = mm.exists(int'(e_addr)) ? mm[int'(e_addr)] : 8'hxx;
    rd_val = e_cpu_rdata;
    if (e_we) mm[int'(e_addr)] = e_dout;
    if (rst) begin
      n_addr = '0; n_dout = '0; n_we = 1'b0; n_ack = 1'b0; n_rdata = '0;
      n_busy = 1'b0; n_dma_rd = 1'b0; n_cpu_rd = 1'b0; n_starve = 0;
    end else begin
      n_ack = e_busy;
      n_rdata = (e_busy && e_dma_rd) ? rd_val : e_rdata;
      n_we = 1'b0; n_addr = e_addr; n_dout = e_dout;
      n_busy = gd; n_dma_rd = gd && !dwe; n_cpu_rd = gc && !cwe;
      if (gc) begin n_addr = caddr; n_dout = cwd; n_we = cwe; end
      else if (gd) begin n_addr = daddr; n_dout = dwd; n_we = dwe; end
      if (!STARVE_EN || !dreq || gd) n_starve = 0;
      else n_starve = (starve < STARVE_MAX) ? starve + 1 : starve;
    end
    cyc++;
  endtask

  task automatic idle(input bit rst);
    step(rst, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 16'h0, 1'b0, 8'h0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      pdata[i] = (i == 0) ? 8'h5C : 8'($urandom);
      pre_we = 1'b1; pre_addr = paddr[i]; pre_data = pdata[i];
      mm[int'(paddr[i])] = pdata[i];
      idle(1'b1);
    end
    pre_we = 1'b0;
    idle(1'b1);
    idle(1'b0);
    n_checks++; if (bus.sram_addr !== 16'h0) begin n_fail++; $display("FAIL reset_sram_addr: got %h expected 0000", bus.sram_addr); end
    n_checks++; if (bus.sram_dout !== 8'h0) begin n_fail++; $display("FAIL reset_sram_dout: got %h expected 00", bus.sram_dout); end
    n_checks++; if (bus.sram_we !== 1'b0) begin n_fail++; $display("FAIL reset_sram_we: got %b expected 0", bus.sram_we); end
    n_checks++; if (bus.dma_ack !== 1'b0) begin n_fail++; $display("FAIL reset_dma_ack: got %b expected 0", bus.dma_ack); end
    n_checks++; if (bus.dma_rdata !== 8'h0) begin n_fail++; $display("FAIL reset_dma_rdata: got %h expected 00", bus.dma_rdata); end
    n_checks++; if (bus.cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rdy: got %b expected 1", bus.cpu_rdy); end
    $display("test_reset: done at cycle %0d", cyc);
  endtask

  task automatic test_cpu_access();
    step(0, 1, 16'h3010, 1, 8'hA5, 0, 16'h0, 0, 8'h0);
    step(0, 1, 16'h3010, 0, 8'h00, 0, 16'h0, 0, 8'h0);
    n_checks++; if (bus.sram_we !== 1'b1) begin n_fail++; $display("FAIL cpu_wr_we: got %b expected 1", bus.sram_we); end
    n_checks++; if (bus.sram_addr !== 16'h3010) begin n_fail++; $display("FAIL cpu_wr_addr: got %h expected 3010", bus.sram_addr); end
    n_checks++; if (bus.sram_dout !== 8'hA5) begin n_fail++; $display("FAIL cpu_wr_dout: got %h expected a5", bus.sram_dout); end
    idle(1'b0);
    n_checks++; if (bus.sram_we !== 1'b0) begin n_fail++; $display("FAIL cpu_rd_we: got %b expected 0", bus.sram_we); end
    n_checks++; if (bus.cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL cpu_rd_data: got %h expected a5", bus.cpu_rdata); end
    n_checks++; if (bus.cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL cpu_rdy: got %b expected 1", bus.cpu_rdy); end
    $display("test_cpu_access: write/read 3010 done at cycle %0d", cyc);
  endtask

  task automatic test_dma_read();
    step(0, 0, 16'h0, 0, 8'h0, 1, 16'h0200, 0, 8'h0);
    n_checks++; if (bus.cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL dma_rd_rdy0: got %b expected 1", bus.cpu_rdy); end
    step(0, 0, 16'h0, 0, 8'h0, 1, 16'h0200, 0, 8'h0);
    n_checks++; if (bus.sram_addr !== 16'h0200) begin n_fail++; $display("FAIL dma_rd_addr: got %h expected 0200", bus.sram_addr); end
    n_checks++; if (bus.sram_we !== 1'b0) begin n_fail++; $display("FAIL dma_rd_we: got %b expected 0", bus.sram_we); end
    n_checks++; if (bus.dma_ack !== 1'b0) begin n_fail++; $display("FAIL dma_rd_early_ack: got %b expected 0", bus.dma_ack); end
    step(0, 0, 16'h0, 0, 8'h0, 0, 16'h0, 0, 8'h0);
    n_checks++; if (bus.dma_ack !== 1'b1) begin n_fail++; $display("FAIL dma_rd_ack: got %b expected 1", bus.dma_ack); end
    n_checks++; if (bus.dma_rdata !== 8'h5C) begin n_fail++; $display("FAIL dma_rd_data: got %h expected 5c", bus.dma_rdata); end
    n_checks++; if (bus.cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL dma_rd_rdy2: got %b expected 1", bus.cpu_rdy); end
    idle(1'b0);
    n_checks++; if (bus.dma_ack !== 1'b0) begin n_fail++; $display("FAIL dma_rd_ack_width: got %b expected 0", bus.dma_ack); end
    n_checks++; if (bus.dma_rdata !== 8'h5C) begin n_fail++; $display("FAIL dma_rd_hold: got %h expected 5c", bus.dma_rdata); end
    $display("test_dma_read: read 0200 done at cycle %0d", cyc);
  endtask

  task automatic test_back_to_back();
    step(0, 0, 16'h0, 0, 8'h0, 1, paddr[0], 0, 8'h0);
    step(0, 0, 16'h0, 0, 8'h0, 1, paddr[0], 0, 8'h0);
    n_checks++; if (bus.sram_addr !== paddr[0]) begin n_fail++; $display("FAIL b2b_addr_a: got %h expected %h", bus.sram_addr, paddr[0]); end
    step(0, 0, 16'h0, 0, 8'h0, 1, paddr[5], 0, 8'h0);
    n_checks++; if (bus.dma_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack_a: got %b expected 1", bus.dma_ack); end
    n_checks++; if (bus.dma_rdata !== pdata[0]) begin n_fail++; $display("FAIL b2b_data_a: got %h expected %h", bus.dma_rdata, pdata[0]); end
    step(0, 0, 16'h0, 0, 8'h0, 1, paddr[5], 0, 8'h0);
    n_checks++; if (bus.sram_addr !== paddr[5]) begin n_fail++; $display("FAIL b2b_addr_b: got %h expected %h", bus.sram_addr, paddr[5]); end
    n_checks++; if (bus.dma_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %b expected 0", bus.dma_ack); end
    step(0, 0, 16'h0, 0, 8'h0, 0, 16'h0, 0, 8'h0);
    n_checks++; if (bus.dma_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack_b: got %b expected 1", bus.dma_ack); end
    n_checks++; if (bus.dma_rdata !== pdata[5]) begin n_fail++; $display("FAIL b2b_data_b: got %h expected %h", bus.dma_rdata, pdata[5]); end
    idle(1'b0);
    $display("test_back_to_back: two DMA reads done at cycle %0d", cyc);
  endtask

  task automatic test_starve();
`ifdef SRAM_ARB_STARVE_EN
    for (int k = 0; k < 12; k++) begin
      step(0, 1, paddr[5], 0, 8'h0, k < 10, paddr[1], 0, 8'h0);
      n_checks++; if (bus.cpu_rdy !== (k != STARVE_MAX)) begin n_fail++; $display("FAIL starve_rdy k=%0d: got %b expected %b", k, bus.cpu_rdy, k != STARVE_MAX); end
      n_checks++; if (bus.dma_ack !== (k == STARVE_MAX + 2)) begin n_fail++; $display("FAIL starve_ack k=%0d: got %b expected %b", k, bus.dma_ack, k == STARVE_MAX + 2); end
      if (k == STARVE_MAX + 1) begin
        n_checks++; if (bus.sram_addr !== paddr[1]) begin n_fail++; $display("FAIL starve_dma_addr: got %h expected %h", bus.sram_addr, paddr[1]); end
      end
      if (k == STARVE_MAX + 2) begin
        n_checks++; if (bus.dma_rdata !== pdata[1]) begin n_fail++; $display("FAIL starve_dma_data: got %h expected %h", bus.dma_rdata, pdata[1]); end
      end
      if (k == STARVE_MAX + 3) begin
        n_checks++; if (bus.sram_addr !== paddr[5]) begin n_fail++; $display("FAIL starve_cpu_resume: got %h expected %h", bus.sram_addr, paddr[5]); end
      end
    end
    $display("test_starve: forced DMA slot done at cycle %0d", cyc);
`else
    for (int k = 0; k < 100; k++) begin
      step(0, 1, paddr[5], 0, 8'h0, 1, paddr[1], 0, 8'h0);
      n_checks++; if (bus.dma_ack !== 1'b0) begin n_fail++; $display("FAIL nostarve_ack k=%0d: got %b expected 0", k, bus.dma_ack); end
      n_checks++; if (bus.cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL nostarve_rdy k=%0d: got %b expected 1", k, bus.cpu_rdy); end
    end
    step(0, 0, 16'h0, 0, 8'h0, 1, paddr[1], 0, 8'h0);
    step(0, 0, 16'h0, 0, 8'h0, 1, paddr[1], 0, 8'h0);
    step(0, 0, 16'h0, 0, 8'h0, 0, 16'h0, 0, 8'h0);
    n_checks++; if (bus.dma_ack !== 1'b1) begin n_fail++; $display("FAIL nostarve_release_ack: got %b expected 1", bus.dma_ack); end
    n_checks++; if (bus.dma_rdata !== pdata[1]) begin n_fail++; $display("FAIL nostarve_release_data: got %h expected %h", bus.dma_rdata, pdata[1]); end
    $display("test_starve: CPU priority held 100 cycles, done at cycle %0d", cyc);
`endif
  endtask

  task automatic test_cancel();
    for (int k = 0; k < 6; k++) begin
      step(0, 1, paddr[2], 0, 8'h0, k < 3, paddr[6], 1, 8'h77);
      n_checks++; if (bus.sram_we !== 1'b0) begin n_fail++; $display("FAIL cancel_we k=%0d: got %b expected 0", k, bus.sram_we); end
      n_checks++; if (bus.dma_ack !== 1'b0) begin n_fail++; $display("FAIL cancel_ack k=%0d: got %b expected 0", k, bus.dma_ack); end
    end
    // A fresh request must wait a full STARVE_MAX window again.
    for (int k = 0; k < STARVE_MAX; k++) begin
      step(0, 1, paddr[2], 0, 8'h0, 1, paddr[6], 1, 8'h77);
      n_checks++; if (bus.cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL cancel_cleared_rdy k=%0d: got %b expected 1", k, bus.cpu_rdy); end
    end
    for (int k = 0; k < 3; k++) begin
      idle(1'b0);
      n_checks++; if (bus.dma_ack !== 1'b0) begin n_fail++; $display("FAIL cancel2_ack k=%0d: got %b expected 0", k, bus.dma_ack); end
      if (k > 0) begin
        n_checks++; if (bus.sram_we !== 1'b0) begin n_fail++; $display("FAIL cancel2_we k=%0d: got %b expected 0", k, bus.sram_we); end
      end
    end
    $display("test_cancel: cancelled DMA requests done at cycle %0d", cyc);
  endtask

  task automatic test_reset_mid_dma();
    step(0, 0, 16'h0, 0, 8'h0, 1, paddr[2], 1, 8'h3C);
    step(1, 0, 16'h0, 0, 8'h0, 0, 16'h0, 0, 8'h0);
    n_checks++; if (bus.sram_we !== 1'b1) begin n_fail++; $display("FAIL rstdma_we: got %b expected 1", bus.sram_we); end
    n_checks++; if (bus.sram_addr !== paddr[2]) begin n_fail++; $display("FAIL rstdma_addr: got %h expected %h", bus.sram_addr, paddr[2]); end
    idle(1'b0);
    n_checks++; if (bus.dma_ack !== 1'b0) begin n_fail++; $display("FAIL rstdma_ack: got %b expected 0", bus.dma_ack); end
    n_checks++; if (bus.sram_we !== 1'b0) begin n_fail++; $display("FAIL rstdma_post_we: got %b expected 0", bus.sram_we); end
    n_checks++; if (bus.sram_addr !== 16'h0) begin n_fail++; $display("FAIL rstdma_post_addr: got %h expected 0000", bus.sram_addr); end
    n_checks++; if (bus.sram_dout !== 8'h0) begin n_fail++; $display("FAIL rstdma_post_dout: got %h expected 00", bus.sram_dout); end
    n_checks++; if (bus.dma_rdata !== 8'h0) begin n_fail++; $display("FAIL rstdma_post_rdata: got %h expected 00", bus.dma_rdata); end
    n_checks++; if (bus.cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL rstdma_post_rdy: got %b expected 1", bus.cpu_rdy); end
    idle(1'b0);
    n_checks++; if (bus.dma_ack !== 1'b0) begin n_fail++; $display("FAIL rstdma_late_ack: got %b expected 0", bus.dma_ack); end
    $display("test_reset_mid_dma: done at cycle %0d", cyc);
  endtask

  task automatic test_random();
    bit d_act = 1'b0;
    logic [15:0] da = '0;
    bit dw = 1'b0;
    logic [7:0] dd = '0;
    int acks = 0;
    for (int c = 0; c < 300; c++) begin
      if (n_ack) d_act = 1'b0;
      else if (d_act && $urandom_range(0, 15) == 0) d_act = 1'b0;
      else if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1'b1; da = paddr[$urandom_range(0, 7)];
        dw = 1'($urandom_range(0, 1)); dd = 8'($urandom);
      end
      step(0, $urandom_range(0, 3) != 0, paddr[$urandom_range(0, 7)],
           $urandom_range(0, 3) == 0, 8'($urandom), d_act, da, dw, dd);
      if (e_ack) acks++;
      n_checks++; if (bus.sram_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr c=%0d: got %h expected %h", c, bus.sram_addr, e_addr); end
      n_checks++; if (bus.sram_dout !== e_dout) begin n_fail++; $display("FAIL rnd_dout c=%0d: got %h expected %h", c, bus.sram_dout, e_dout); end
      n_checks++; if (bus.sram_we !== e_we) begin n_fail++; $display("FAIL rnd_we c=%0d: got %b expected %b", c, bus.sram_we, e_we); end
      n_checks++; if (bus.dma_ack !== e_ack) begin n_fail++; $display("FAIL rnd_ack c=%0d: got %b expected %b", c, bus.dma_ack, e_ack); end
      n_checks++; if (bus.dma_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_dma_rdata c=%0d: got %h expected %h", c, bus.dma_rdata, e_rdata); end
      n_checks++; if (bus.cpu_rdy !== e_rdy) begin n_fail++; $display("FAIL rnd_rdy c=%0d: got %b expected %b", c, bus.cpu_rdy, e_rdy); end
      if (e_cpu_rd) begin
        n_checks++; if (bus.cpu_rdata !== e_cpu_rdata) begin n_fail++; $display("FAIL rnd_cpu_rdata c=%0d: got %h expected %h", c, bus.cpu_rdata, e_cpu_rdata); end
      end
    end
    $display("test_random: 300 cycles, %0d DMA acks, done at cycle %0d", acks, cyc);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    reset = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_we = 1'b0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_addr = '0; bus.dma_we = 1'b0; bus.dma_wdata = '0;
    n_addr = '0; n_dout = '0; n_we = 1'b0; n_ack = 1'b0; n_rdata = '0;
    n_busy = 1'b0; n_dma_rd = 1'b0; n_cpu_rd = 1'b0; n_starve = 0;
    test_reset();
    test_cpu_access();
    test_dma_read();
    test_back_to_back();
    test_starve();
    test_cancel();
    test_reset_mid_dma();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 8, meaning the number of consecutive DMA wait cycles after which DMA is forced a slot (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on posedge clk.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port cpu_req, input, 1, meaning CPU address decodes to SRAM pages (0x0xxx/0x3xxx).
REQ-005 SHALL have port cpu_addr, input, 16, the CPU address.
REQ-006 SHALL have port cpu_we, input, 1, the CPU write strobe.
REQ-007 SHALL have port cpu_wdata, input, 8, the CPU write data.
REQ-008 SHALL have port cpu_rdata, output, 8, the CPU read data.
REQ-009 SHALL have port cpu_rdy, output, 1, CPU ready; low stalls the CPU.
REQ-010 SHALL have port dma_req, input, 1, the DMA request; held until dma_ack.
REQ-011 SHALL have port dma_addr, input, 16, the DMA address.
REQ-012 SHALL have port dma_we, input, 1, the DMA write strobe.
REQ-013 SHALL have port dma_wdata, input, 8, the DMA write data.
REQ-014 SHALL have port dma_ack, output, 1, a one-cycle completion pulse.
REQ-015 SHALL have port dma_rdata, output, 8, the DMA read data, valid with dma_ack.
REQ-016 SHALL have port sram_addr, output, 16, the registered SRAM address.
REQ-017 SHALL have port sram_dout, output, 8, the registered SRAM write data.
REQ-018 SHALL have port sram_din, input, 8, the asynchronous SRAM read data.
REQ-019 SHALL have port sram_we, output, 1, the registered SRAM write enable.

Function
REQ-020 SHALL use FSM states IDLE, CPU, DMA, where state = owner of the access cycle in progress.
REQ-021 SHALL decide grant in cycle N from requests sampled in cycle N: CPU if cpu_req and not forced, else DMA if dma_req and no DMA access pending, else none.
REQ-022 SHALL register the grantee's addr, wdata and we into sram_addr/sram_dout/sram_we at the end of cycle N; the access occupies cycle N+1; with no grant, sram_we=0 and sram_addr/sram_dout hold.
REQ-023 SHALL drive cpu_rdata = sram_din combinationally, matching the one-cycle registered read path.
REQ-024 SHALL, on a DMA access, capture sram_din into dma_rdata at the end of N+1 and pulse dma_ack high for exactly cycle N+2.
REQ-025 SHALL hold dma_rdata stable until the next DMA read completes.
REQ-026 SHALL not re-grant DMA in N+1 for the same request (requester deasserts on ack); back-to-back DMA transfers have a throughput of one per 2 cycles.
REQ-027 SHALL keep cpu_rdy=1 except as in REQ-029.
REQ-028 SHALL, when cpu_req=0, give the DMA request the slot with no stall.
REQ-029 SHALL, with SRAM_ARB_STARVE_EN, force DMA when the starve counter reaches STARVE_MAX and cpu_req=1; cpu_rdy=0 combinationally for that cycle N only.
REQ-030 SHALL increment the 8-bit starve counter each cycle dma_req=1 and DMA is not granted, saturate it at STARVE_MAX, and clear it on DMA grant or dma_req=0.
REQ-031 SHALL, if dma_req deasserts before grant, cancel with no ack and no SRAM cycle.

Reset
REQ-032 SHALL, on reset, set state IDLE, sram_addr=0, sram_dout=0, sram_we=0, dma_ack=0, dma_rdata=0, starve counter=0, cpu_rdy=1.
REQ-033 SHALL, on reset asserted mid-DMA (state DMA or ack pending), issue no dma_ack after reset releases; the requester re-requests.

Configuration
REQ-034 SHALL, when SRAM_ARB_STARVE_EN is defined, include the starve counter and the REQ-029 forced DMA slot.
REQ-035 SHALL, when SRAM_ARB_STARVE_EN is undefined, give the CPU absolute priority, hold cpu_rdy constant 1, and omit the counter; DMA may starve indefinitely.

Verification
REQ-036 SHALL cover: CPU write 0x3010<=0xA5 then read -> sram_we=1 one cycle after, with sram_addr=0x3010 and sram_dout=0xA5; read returns cpu_rdata=0xA5.
REQ-037 SHALL cover: DMA read 0x0200 (preloaded 0x5C) with cpu_req=0 -> sram_addr=0x0200 at N+1, dma_ack at N+2 with dma_rdata=0x5C, cpu_rdy constantly 1.
REQ-038 SHALL cover: cpu_req held 1 and dma_req 1 with STARVE_EN and STARVE_MAX=8 -> DMA granted exactly after 8 wait cycles, cpu_rdy=0 for one cycle, then CPU resumes.
REQ-039 SHALL cover: the same stimulus as REQ-038 without the macro -> no dma_ack for 100 cycles and cpu_rdy constant 1.
REQ-040 SHALL cover: DMA write granted, reset pulsed in N+1 -> no dma_ack, all outputs at reset values the cycle after reset.
REQ-041 SHALL cover: dma_req raised and dropped before grant (cpu_req=1) -> no sram_we, no dma_ack, starve counter cleared.
